// File: rtl/cheri_bgeng_arb.sv
// cheri_bgeng_arb: arbitrates NMstr background-engine masters onto the single
// LSU background port. A request is presented combinationally in IDLE (zero-wait
// accept) and the grant is locked in LOCK until the LSU accepts it. Accepted grant
// indices are queued so that LSU responses are routed back in order.
// Optional feature macro: CHERI_BGENG_ARB_RR_EN selects round-robin normal priority
// (undefined: fixed priority with master 0 highest).
module cheri_bgeng_arb #(
   parameter int NMstr     = 2,
   parameter int MaxOutstd = 2,
   parameter int StarveLim = 15
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NMstr-1:0]     mstr_req_i,
   input  logic [NMstr-1:0]     mstr_is_cap_i,
   input  logic [NMstr-1:0]     mstr_we_i,
   input  logic [32*NMstr-1:0]  mstr_addr_i,
   input  logic [33*NMstr-1:0]  mstr_wdata_i,
   output logic [NMstr-1:0]     mstr_req_done_o,
   output logic [NMstr-1:0]     mstr_resp_valid_o,
   input  logic                 lsu_sel_i,
   input  logic                 lsu_req_done_i,
   input  logic                 lsu_resp_valid_i,
   output logic                 lsu_req_o,
   output logic                 lsu_is_cap_o,
   output logic                 lsu_we_o,
   output logic [31:0]          lsu_addr_o,
   output logic [32:0]          lsu_wdata_o,
   output logic [NMstr-1:0]     starve_o,
   output logic                 resp_err_o,
   output logic                 busy_o
);

   localparam int IdxW  = (NMstr > 2) ? 2 : 1;
   localparam int PtrW  = (MaxOutstd > 2) ? 2 : 1;
   localparam int Depth = 1 << PtrW;
   localparam logic [2:0]      DepthC  = 3'(MaxOutstd);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstd - 1);
   localparam logic [3:0]      LimC    = 4'(StarveLim);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_e;

   // FIFO pointers wrap at the configured depth, which need not be a power of two.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrLast) ? {PtrW{1'b0}} : p + PtrW'(1);
   endfunction

   state_e              state_r, state_nxt_s;
   logic [IdxW-1:0]     gnt_q, gnt_nxt_s;
   logic [IdxW-1:0]     gnt_s;
   logic                gnt_vld_s;
   logic [IdxW-1:0]     starve_sel_s, norm_sel_s;
   logic [NMstr-1:0]    starve_s, starve_req_s;
   logic [3:0]          cnt_r [NMstr];

   logic                req_gnt_s, is_cap_s, we_s;
   logic [31:0]         addr_s;
   logic [32:0]         wdata_s;
   logic                block_s, req_s, done_s;
   logic [NMstr-1:0]    done_vec_s, resp_vec_s;

   logic [IdxW-1:0]     fifo_r [Depth];
   logic [PtrW-1:0]     wr_ptr_r, rd_ptr_r;
   logic [2:0]          count_r;
   logic                full_s, empty_s, push_s, pop_s;
   logic [IdxW-1:0]     head_s;
   logic                err_r;

`ifdef CHERI_BGENG_ARB_RR_EN
   logic [IdxW-1:0]     rr_ptr_r;
`endif

   // Starvation flags and the two candidate grants (starving first, then normal priority).
   always_comb begin
      starve_s     = '0;
      starve_sel_s = '0;
      norm_sel_s   = '0;
      for (int i = 0; i < NMstr; i++) begin
         starve_s[i] = (cnt_r[i] == LimC);
      end
      starve_req_s = starve_s & mstr_req_i;
      // Descending scan: the last hit is the lowest requesting index.
      for (int i = NMstr - 1; i >= 0; i--) begin
         starve_sel_s = starve_req_s[i] ? IdxW'(i) : starve_sel_s;
      end
`ifdef CHERI_BGENG_ARB_RR_EN
      // Scan offsets from far to near so the master right after the last grant wins.
      for (int k = NMstr - 1; k >= 0; k--) begin
         for (int j = 0; j < NMstr; j++) begin
            norm_sel_s = ((j == (int'(rr_ptr_r) + 1 + k) % NMstr) && mstr_req_i[j])
                         ? IdxW'(j) : norm_sel_s;
         end
      end
`else
      for (int i = NMstr - 1; i >= 0; i--) begin
         norm_sel_s = mstr_req_i[i] ? IdxW'(i) : norm_sel_s;
      end
`endif
   end

   // Effective grant: computed live in IDLE, held from gnt_q in LOCK.
   always_comb begin
      gnt_s     = gnt_q;
      gnt_vld_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            gnt_s     = (|starve_req_s) ? starve_sel_s : norm_sel_s;
            gnt_vld_s = |mstr_req_i;
         end
         ST_LOCK: begin
            gnt_s     = gnt_q;
            gnt_vld_s = 1'b1;
         end
         default: begin
            gnt_s     = gnt_q;
            gnt_vld_s = 1'b0;
         end
      endcase
   end

   // Request-side mux of the granted master; all-zero without a grant.
   always_comb begin
      req_gnt_s = 1'b0;
      is_cap_s  = 1'b0;
      we_s      = 1'b0;
      addr_s    = 32'h0000_0000;
      wdata_s   = 33'h0_0000_0000;
      for (int i = 0; i < NMstr; i++) begin
         if (gnt_vld_s && (gnt_s == IdxW'(i))) begin
            req_gnt_s = mstr_req_i[i];
            is_cap_s  = mstr_is_cap_i[i];
            we_s      = mstr_we_i[i];
            addr_s    = mstr_addr_i[32*i +: 32];
            wdata_s   = mstr_wdata_i[33*i +: 33];
         end else begin
            req_gnt_s = req_gnt_s;
         end
      end
   end

   // Back-pressure, accept and response routing. A full FIFO only blocks when
   // no pop frees an entry in the same cycle.
   always_comb begin
      full_s     = (count_r == DepthC);
      empty_s    = (count_r == 3'd0);
      block_s    = full_s && !lsu_resp_valid_i;
      req_s      = req_gnt_s && !block_s;
      done_s     = lsu_req_done_i && gnt_vld_s && !block_s;
      push_s     = done_s;
      pop_s      = lsu_resp_valid_i && !empty_s;
      head_s     = fifo_r[rd_ptr_r];
      done_vec_s = '0;
      resp_vec_s = '0;
      for (int i = 0; i < NMstr; i++) begin
         done_vec_s[i] = done_s && (gnt_s == IdxW'(i));
         resp_vec_s[i] = pop_s && (head_s == IdxW'(i));
      end
   end

   // FSM next state: lock a pending request, release on accept or on a cancelled write.
   always_comb begin
      state_nxt_s = state_r;
      gnt_nxt_s   = gnt_q;
      case (state_r)
         ST_IDLE: begin
            if (gnt_vld_s && !done_s) begin
               state_nxt_s = ST_LOCK;
               gnt_nxt_s   = gnt_s;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOCK: begin
            if (done_s) begin
               state_nxt_s = ST_IDLE;
            end else if (!req_gnt_s && !lsu_sel_i) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_LOCK;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            gnt_nxt_s   = '0;
         end
      endcase
   end

   // FSM state and locked grant registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= ST_IDLE;
         gnt_q   <= '0;
      end else begin
         state_r <= state_nxt_s;
         gnt_q   <= gnt_nxt_s;
      end
   end

   // Response-routing FIFO of accepted grant indices.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= 3'd0;
         for (int i = 0; i < Depth; i++) begin
            fifo_r[i] <= '0;
         end
      end else begin
         if (push_s) begin
            fifo_r[wr_ptr_r] <= gnt_s;
            wr_ptr_r         <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 3'd1;
            2'b01:   count_r <= count_r - 3'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky orphan-response flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_r <= 1'b0;
      end else if (lsu_resp_valid_i && empty_s) begin
         err_r <= 1'b1;
      end
   end

   // Per-master saturating wait counters.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NMstr; i++) begin
         if (rst_i) begin
            cnt_r[i] <= 4'd0;
         end else if (!mstr_req_i[i] || done_vec_s[i]) begin
            cnt_r[i] <= 4'd0;
         end else if (cnt_r[i] < LimC) begin
            cnt_r[i] <= cnt_r[i] + 4'd1;
         end
      end
   end

`ifdef CHERI_BGENG_ARB_RR_EN
   // Round-robin pointer remembers the last accepted master.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_r <= IdxW'(NMstr - 1);
      end else if (done_s) begin
         rr_ptr_r <= gnt_s;
      end
   end
`endif

   // Outputs are forced to zero for as long as reset is held.
   assign lsu_req_o         = rst_i ? 1'b0 : req_s;
   assign lsu_is_cap_o      = rst_i ? 1'b0 : is_cap_s;
   assign lsu_we_o          = rst_i ? 1'b0 : we_s;
   assign lsu_addr_o        = rst_i ? 32'h0000_0000 : addr_s;
   assign lsu_wdata_o       = rst_i ? 33'h0_0000_0000 : wdata_s;
   assign mstr_req_done_o   = rst_i ? '0 : done_vec_s;
   assign mstr_resp_valid_o = rst_i ? '0 : resp_vec_s;
   assign starve_o          = rst_i ? '0 : starve_s;
   assign resp_err_o        = rst_i ? 1'b0 : err_r;
   assign busy_o            = rst_i ? 1'b0 : ((state_r == ST_LOCK) || !empty_s);

endmodule
